reg_file: RTL and testbench

General-purpose register file for the simple_cpu datapath: 32 registers, one synchronous write port and two combinational read ports. The write port is the inverse of the datapath's operand-select muxes: it demultiplexes one result onto one of N registers. rs1/rs2 operands leave through the read ports to the ALU source muxes, and writeback data returns through the write port. Register x0 is hardwired to zero.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/wr_decoder.sv | 23 ++
 rtl/reg_file.sv | 67 ++++++
 tb/tb_reg_file.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants for simple_cpu: register width, count and
// the hardwired-zero register index.
package cpu_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/wr_decoder.sv
// Write-port demultiplexer: turns a register index into a one-hot enable
// vector. Entry 0 is never enabled, so x0 can never be written.
module wr_decoder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = NUM_REGS
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DEPTH-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (en && addr == ADDR_W'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port, two
// combinational read ports with optional write-through bypass; x0 reads 0.
module reg_file
    import cpu_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int DEPTH  = NUM_REGS,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] wr_en;

    wr_decoder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_wr_decoder (
        .en     (we),
        .addr   (waddr),
        .onehot (wr_en)
    );

    // Reset wins over a coincident write; wr_en[0] is always low so x0 stays 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == ADDR_W'(ZERO_REG)) begin
            rdata1 = '0;
        end else if (BYPASS != 0 && !rst && we && waddr == raddr1) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == ADDR_W'(ZERO_REG)) begin
            rdata2 = '0;
        end else if (BYPASS != 0 && !rst && we && waddr == raddr2) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one bypassing and one non-bypassing instance
// driven from the same inputs, checked against hand-computed values.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata1, rdata2;
    logic [31:0] rdata1_nb, rdata2_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file #(.BYPASS(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    reg_file #(.BYPASS(0)) dut_nb (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .rdata1 (rdata1_nb),
        .raddr2 (raddr2),
        .rdata2 (rdata2_nb)
    );

    // Inputs change on the falling edge, so each call spans one rising edge.
    task automatic applyStimulus(input logic r, input logic w, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [4:0] ra1,
                                 input logic [4:0] ra2);
        @(negedge clk);
        rst    = r;
        we     = w;
        waddr  = wa;
        wdata  = wd;
        raddr1 = ra1;
        raddr2 = ra2;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        logic [31:0] exp1, exp2;

        // Reset, then read two arbitrary registers
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        checkOutput("reset_rd1", rdata1, 32'h0);
        checkOutput("reset_rd2", rdata2, 32'h0);
        checkOutput("reset_nb_rd1", rdata1_nb, 32'h0);

        // Write then read back
        applyStimulus(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd1, 5'd2);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        checkOutput("wr_rd1", rdata1, 32'hA5A5A5A5);
        checkOutput("wr_rd2", rdata2, 32'h0);
        checkOutput("wr_nb_rd1", rdata1_nb, 32'hA5A5A5A5);

        // x0 is immutable and never bypassed
        applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        checkOutput("x0_bypass_rd1", rdata1, 32'h0);
        checkOutput("x0_bypass_rd2", rdata2, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("x0_after_rd1", rdata1, 32'h0);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
            exp1 = (i == 3) ? 32'hA5A5A5A5 : 32'h0;
            checkOutput($sformatf("x0_sweep_rd1[%0d]", i), rdata1, exp1);
            checkOutput($sformatf("x0_sweep_rd2[%0d]", i), rdata2, exp1);
        end

        // Same-cycle forwarding, both ports on one index
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h5A5A5A5A, 5'd7, 5'd7);
        checkOutput("byp_rd1", rdata1, 32'h5A5A5A5A);
        checkOutput("byp_rd2", rdata2, 32'h5A5A5A5A);
        checkOutput("nobyp_rd1", rdata1_nb, 32'h11111111);
        checkOutput("nobyp_rd2", rdata2_nb, 32'h11111111);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        checkOutput("byp_after_rd1", rdata1, 32'h5A5A5A5A);
        checkOutput("nobyp_after_rd1", rdata1_nb, 32'h5A5A5A5A);
        checkOutput("nobyp_after_rd2", rdata2_nb, 32'h5A5A5A5A);

        // Reset beats a coincident write; bypass is off while rst is high
        applyStimulus(1'b0, 1'b1, 5'd9, 32'hDEADBEEF, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h12345678, 5'd9, 5'd7);
        checkOutput("rstpri_pre_rd1", rdata1, 32'hDEADBEEF);
        checkOutput("rstpri_pre_rd2", rdata2, 32'h5A5A5A5A);
        checkOutput("rstpri_pre_nb_rd1", rdata1_nb, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7);
        checkOutput("rstpri_post_rd1", rdata1, 32'h0);
        checkOutput("rstpri_post_rd2", rdata2, 32'h0);
        checkOutput("rstpri_post_nb_rd1", rdata1_nb, 32'h0);

        // Walking writes, then opposite-direction sweeps on the two ports
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            exp1 = 32'(i) * 32'h01010101;
            exp2 = 32'(31 - i) * 32'h01010101;
            checkOutput($sformatf("walk_rd1[%0d]", i), rdata1, exp1);
            checkOutput($sformatf("walk_rd2[%0d]", 31 - i), rdata2, exp2);
            checkOutput($sformatf("walk_nb_rd1[%0d]", i), rdata1_nb, exp1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
